// File: rtl/pipe_addsub_pkg.sv
// rtl/pipe_addsub_pkg.sv - shared constants and helpers for the pipelined adder/subtractor
package pipe_addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic logic signed_ovf(input logic carry_into_msb, input logic carry_out_msb);
        return carry_into_msb ^ carry_out_msb;
    endfunction

    function automatic bit cfg_ok(input int width, input int stages);
        return (stages > 0) && (width > 0) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/addsub_seg.sv
// rtl/addsub_seg.sv - one SEG-bit carry segment with its stage register
module addsub_seg #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] s_in,
    input  logic             c_in,
    input  logic             sub_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic [WIDTH-1:0] s_q,
    output logic             c_q,
    output logic             sub_q,
    output logic             cmsb_q
);

    localparam int LO = K * SEG;

    logic [SEG:0]     seg_full;
    logic [WIDTH-1:0] s_next;
    logic             cmsb;

    always_comb begin
        seg_full = {1'b0, a_in[LO +: SEG]} + {1'b0, b_in[LO +: SEG]} + {{SEG{1'b0}}, c_in};
        s_next = s_in;
        s_next[LO +: SEG] = seg_full[SEG-1:0];
    end

    // Carry into the segment's top bit, recovered from that bit's sum and operands.
    assign cmsb = seg_full[SEG-1] ^ a_in[LO+SEG-1] ^ b_in[LO+SEG-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= '0;
            c_q       <= 1'b0;
            sub_q     <= 1'b0;
            cmsb_q    <= 1'b0;
        end else if (go) begin
            out_valid <= in_valid;
            // Bubbles move the valid bit only, so idle inputs never disturb held data.
            if (in_valid) begin
                a_q    <= a_in;
                b_q    <= b_in;
                s_q    <= s_next;
                c_q    <= seg_full[SEG];
                sub_q  <= sub_in;
                cmsb_q <= cmsb;
            end
        end
    end

endmodule

// File: rtl/pipe_addsub.sv
// rtl/pipe_addsub.sv - pipelined WIDTH-bit add/subtract with valid/ready on both sides
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int SEG = WIDTH / STAGES;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
        $error("pipe_addsub: WIDTH must be a positive multiple of STAGES");
    end

    // Index k is the input of stage k; index k+1 is its registered output.
    logic [STAGES:0][WIDTH-1:0] a_v, b_v, s_v;
    logic [STAGES:0]            v_v, c_v, sub_v, go;
    logic [STAGES-1:0]          cmsb_v;
    logic                       unused_tail;

    assign v_v[0]   = in_valid;
    assign a_v[0]   = a;
    assign b_v[0]   = (sub == MODE_SUB) ? ~b : b;
    assign s_v[0]   = '0;
    assign c_v[0]   = (sub == MODE_ADD) ? c_in : ~c_in;
    assign sub_v[0] = sub;

    always_comb begin
        go = '0;
        go[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            go[k] = !v_v[k+1] | go[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        addsub_seg #(.WIDTH(WIDTH), .SEG(SEG), .K(k)) u_seg (
            .clk       (clk),
            .rst       (rst),
            .go        (go[k]),
            .in_valid  (v_v[k]),
            .a_in      (a_v[k]),
            .b_in      (b_v[k]),
            .s_in      (s_v[k]),
            .c_in      (c_v[k]),
            .sub_in    (sub_v[k]),
            .out_valid (v_v[k+1]),
            .a_q       (a_v[k+1]),
            .b_q       (b_v[k+1]),
            .s_q       (s_v[k+1]),
            .c_q       (c_v[k+1]),
            .sub_q     (sub_v[k+1]),
            .cmsb_q    (cmsb_v[k])
        );
    end

    assign in_ready  = go[0];
    assign out_valid = v_v[STAGES];
    assign sum       = s_v[STAGES];
    assign c_out     = c_v[STAGES];
    assign ovf       = signed_ovf(cmsb_v[STAGES-1], c_v[STAGES]);

    // Operand copies leaving the last stage have no consumer.
    assign unused_tail = ^{a_v[STAGES], b_v[STAGES], sub_v[STAGES], cmsb_v};

endmodule

// File: tb/tb_pipe_addsub.sv
// tb/tb_pipe_addsub.sv - scoreboard bench for pipe_addsub (16/4 and exhaustive 4/2)
module tb_pipe_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, c_in, sub, c_out, ovf;
    logic [15:0] a, b, sum;
    logic        in_valid2, in_ready2, out_valid2, out_ready2, c_in2, sub2, c_out2, ovf2;
    logic [3:0]  a2, b2, sum2;

    pipe_addsub #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .c_in(c_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    pipe_addsub #(.WIDTH(4), .STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
        .c_in(c_in2), .sub(sub2), .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .c_out(c_out2), .ovf(ovf2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [17:0] exp_q[$];
    logic [17:0] exp2_q[$];
    logic [17:0] held;
    bit          stalled = 1'b0;

    // Reference: integer arithmetic on unsigned and signed interpretations.
    function automatic logic [17:0] model(input int w, input int av, input int bv, input bit ci, input bit sb);
        int full, sa, sbv, r, lim, cv;
        logic [15:0] s;
        logic co, o;
        cv  = ci ? 1 : 0;
        lim = 1 << (w - 1);
        if (sb) begin
            full = av - bv - cv;
            co   = (full >= 0);
        end else begin
            full = av + bv + cv;
            co   = (full >= (1 << w));
        end
        s   = 16'(full & ((1 << w) - 1));
        sa  = (av >= lim) ? av - 2 * lim : av;
        sbv = (bv >= lim) ? bv - 2 * lim : bv;
        r   = sb ? sa - sbv - cv : sa + sbv + cv;
        o   = (r < -lim) || (r >= lim);
        return {s, co, o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp2_q.delete();
            stalled = 1'b0;
        end else begin
            if (in_valid && in_ready)
                exp_q.push_back(model(16, int'(a), int'(b), c_in, sub));
            if (in_valid2 && in_ready2)
                exp2_q.push_back(model(4, int'(a2), int'(b2), c_in2, sub2));
            if (stalled)
                check("stall_hold", {13'b0, out_valid, sum, c_out, ovf}, {13'b0, 1'b1, held});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_result: got %0h, expected none", {sum, c_out, ovf});
                end else begin
                    check("result", {14'b0, sum, c_out, ovf}, {14'b0, exp_q.pop_front()});
                end
            end
            if (out_valid2 && out_ready2) begin
                if (exp2_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_result2: got %0h, expected none", {sum2, c_out2, ovf2});
                end else begin
                    check("result2", {26'b0, sum2, c_out2, ovf2}, {14'b0, exp2_q.pop_front()});
                end
            end
            stalled = out_valid && !out_ready;
            held    = {sum, c_out, ovf};
        end
    end

    task automatic rand_op();
        a    = 16'($urandom);
        b    = 16'($urandom);
        c_in = 1'($urandom);
        sub  = 1'($urandom);
    endtask

    task automatic stream(input int n, input int stall_at, input int stall_len, output bit saw_low);
        int sent, cyc;
        bit acc;
        sent = 0;
        cyc = 0;
        saw_low = 1'b0;
        @(posedge clk); #1;
        rand_op();
        in_valid = 1'b1;
        while (sent < n && cyc < 500) begin
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            @(negedge clk);
            acc = in_ready;
            if (!in_ready) saw_low = 1'b1;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                sent++;
                rand_op();
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_sent", sent, n);
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        out_ready  = 1'b1;
        out_ready2 = 1'b1;
        while (t < 200 && (exp_q.size() != 0 || exp2_q.size() != 0)) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check({nm, "_drained"}, exp_q.size() + exp2_q.size(), 0);
        check({nm, "_idle"}, {out_valid, out_valid2}, 2'b00);
    endtask

    task automatic send_expect(input logic [15:0] av, input logic [15:0] bv, input logic ci, input logic sb,
                               input logic [15:0] es, input logic ec, input logic eo, input string nm);
        int t;
        @(posedge clk); #1;
        a = av; b = bv; c_in = ci; sub = sb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        t = 0;
        while (t < 20) begin
            @(negedge clk);
            if (out_valid) break;
            t++;
        end
        check({nm, "_seen"}, out_valid, 1);
        check({nm, "_sum"}, sum, es);
        check({nm, "_cout"}, c_out, ec);
        check({nm, "_ovf"}, ovf, eo);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw;
        int lat;
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid2 = 1'b0; a2 = '0; b2 = '0; c_in2 = 1'b0; sub2 = 1'b0; out_ready2 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", c_out, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid2", out_valid2, 0);

        // Latency and a plain add
        @(posedge clk); #1;
        a = 16'h1234; b = 16'h0FF1; c_in = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 4);
        check("t1_sum", sum, 16'h2226);
        check("t1_cout", c_out, 0);
        check("t1_ovf", ovf, 0);

        // Subtract and wrap-around corners
        send_expect(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, "sub_wrap");
        send_expect(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
        send_expect(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
        drain("directed");

        // Back-to-back streaming
        stream(32, 1000, 0, saw);
        check("stream_in_ready_low", saw, 0);
        drain("stream");

        // Backpressure mid-stream
        stream(10, 3, 6, saw);
        check("bp_in_ready_fell", saw, 1);
        drain("backpressure");

        // Bubble collapse with the consumer stalled
        @(posedge clk); #1;
        out_ready = 1'b0;
        rand_op();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rand_op();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("bubble_two_held_ready", in_ready, 1);
        check("bubble_two_held_valid", out_valid, 1);
        @(posedge clk); #1;
        rand_op();
        in_valid = 1'b1;
        @(negedge clk);
        check("bubble_third_ready", in_ready, 1);
        @(posedge clk); #1;
        rand_op();
        @(negedge clk);
        check("bubble_fourth_ready", in_ready, 1);
        @(posedge clk); #1;
        rand_op();
        @(negedge clk);
        check("bubble_full_ready_low", in_ready, 0);
        @(posedge clk); #1;
        rand_op();
        @(negedge clk);
        check("bubble_full_still_low", in_ready, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain("bubble");

        // Reset with operations in flight
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_op();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush_out_valid", out_valid, 0);
        check("flush_sum", sum, 0);
        check("flush_in_ready", in_ready, 1);
        repeat (8) @(negedge clk);
        check("flush_none_emitted", out_valid, 0);

        // Exhaustive sweep on the narrow instance with random backpressure
        @(posedge clk); #1;
        for (int op = 0; op < 1024; op++) begin
            int t;
            bit acc;
            t = 0;
            acc = 1'b0;
            a2 = 4'(op);
            b2 = 4'(op >> 4);
            c_in2 = 1'(op >> 8);
            sub2 = 1'(op >> 9);
            in_valid2 = 1'b1;
            while (!acc && t < 50) begin
                out_ready2 = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                acc = in_ready2;
                @(posedge clk); #1;
                t++;
            end
            if (!acc) begin
                n_checks++;
                n_fail++;
                $display("FAIL sweep_accept: got timeout at op %0d, expected acceptance", op);
            end
        end
        in_valid2 = 1'b0;
        drain("sweep");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
